// File: rtl/hop_cnt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// hop_cnt_rr_arbiter
//
// Wormhole output arbiter for a mesh router port. Among the requesting inputs
// the one carrying the largest hop count wins. Ties are broken round-robin,
// starting at rr_ptr. Once granted, the output stays locked to the winner
// until its tail flit is transferred.
//
// Optional feature (compile-time macro HOP_ARB_AGING_EN):
//   Each input gets a saturating AGE_W-bit age counter. Every requesting input
//   that loses an arbitration ages by one. The winner's counter clears. An
//   input whose counter is saturated is "starving" and beats any hop count.
//   Without the macro no age state exists and AGE_W is unused.
//
// Handshake (valid/ready):
//   grant_vld_o is the valid, out_rdy_i is the ready, and req_i[grant_idx_o]
//   qualifies that the winner still presents a flit. A flit moves in a cycle
//   only when all three are high. The grant is released only when such a
//   transfer carries tail_i[grant_idx_o]=1. A tail without ready, a dropped
//   request, or a higher-hop newcomer never releases or preempts the grant.
//
// Ports:
//   clk_i        in   clock, rising-edge
//   rst_i        in   synchronous active-high reset
//   req_i        in   [IN_N]             per-input flit present
//   hop_cnt_i    in   [IN_N*HOP_CNT_W]   packed hop counts; input k at
//                                        [k*HOP_CNT_W +: HOP_CNT_W]
//   tail_i       in   [IN_N]             per-input tail-flit flag
//   out_rdy_i    in   downstream accepts a flit this cycle
//   grant_o      out  [IN_N]             registered one-hot grant or zero
//   grant_idx_o  out  [$clog2(IN_N)]     registered winner index
//   grant_vld_o  out  registered OR of grant_o
//   tie_o        out  registered; current grant came from a round-robin tie
//   state_dbg_o  out  FSM state (0 = IDLE, 1 = BUSY)
// -----------------------------------------------------------------------------
module hop_cnt_rr_arbiter #(
  parameter int IN_N      = 5,
  parameter int HOP_CNT_W = 3,
  parameter int AGE_W     = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [IN_N-1:0]           req_i,
  input  logic [IN_N*HOP_CNT_W-1:0] hop_cnt_i,
  input  logic [IN_N-1:0]           tail_i,
  input  logic                      out_rdy_i,
  output logic [IN_N-1:0]           grant_o,
  output logic [$clog2(IN_N)-1:0]   grant_idx_o,
  output logic                      grant_vld_o,
  output logic                      tie_o,
  output logic                      state_dbg_o
);

  localparam int IDX_W = $clog2(IN_N);
  localparam logic [IN_N-1:0] ONE_HOT0 = {{(IN_N-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IN_N-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic              grant_vld_q, grant_vld_d;
  logic              tie_q, tie_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  // ---------------------------------------------------------------------------
  // Winner selection (only consumed while IDLE)
  // ---------------------------------------------------------------------------
  logic [HOP_CNT_W-1:0] max_hop;
  logic [IN_N-1:0]      hop_cand;   // requesters at the maximum hop count
  logic [IN_N-1:0]      cand;       // final candidate set (after aging)
  logic                 multi_cand; // more than one candidate -> tie
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic [IN_N-1:0]      win_oh;

  // Maximum hop count over requesting inputs; non-requesters are ignored.
  // A lone requester with hop 0 still matches max_hop = 0.
  always_comb begin
    max_hop = '0;
    for (int k = 0; k < IN_N; k++) begin
      if (req_i[k] && (hop_cnt_i[k*HOP_CNT_W +: HOP_CNT_W] > max_hop)) begin
        max_hop = hop_cnt_i[k*HOP_CNT_W +: HOP_CNT_W];
      end
    end
  end

  always_comb begin
    hop_cand = '0;
    for (int k = 0; k < IN_N; k++) begin
      hop_cand[k] = req_i[k] && (hop_cnt_i[k*HOP_CNT_W +: HOP_CNT_W] == max_hop);
    end
  end

`ifdef HOP_ARB_AGING_EN
  // ---------------------------------------------------------------------------
  // Starvation avoidance: saturated age counters override hop priority.
  // ---------------------------------------------------------------------------
  logic [AGE_W-1:0] age_q [IN_N];
  logic [AGE_W-1:0] age_d [IN_N];
  logic [IN_N-1:0]  starve;

  always_comb begin
    for (int k = 0; k < IN_N; k++) begin
      starve[k] = req_i[k] && (&age_q[k]);
    end
  end

  assign cand = (|starve) ? starve : hop_cand;

  // Ages move only on an actual IDLE arbitration.
  always_comb begin
    for (int k = 0; k < IN_N; k++) begin
      age_d[k] = age_q[k];
    end
    if ((state_q == IDLE) && (|req_i)) begin
      for (int k = 0; k < IN_N; k++) begin
        if (win_oh[k]) begin
          age_d[k] = '0;
        end else if (req_i[k] && !(&age_q[k])) begin
          age_d[k] = age_q[k] + {{(AGE_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < IN_N; k++) begin
      if (rst_i) begin
        age_q[k] <= '0;
      end else begin
        age_q[k] <= age_d[k];
      end
    end
  end
`else
  assign cand = hop_cand;
`endif

  // Tie detection: set once a second candidate is seen.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    multi_cand = 1'b0;
    for (int k = 0; k < IN_N; k++) begin
      if (cand[k]) begin
        if (seen) begin
          multi_cand = 1'b1;
        end
        seen = 1'b1;
      end
    end
  end

  // Circular scan starting at rr_ptr. The first candidate found wins.
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < IN_N; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= IN_N) begin
        j = j - IN_N;
      end
      if (!win_found && cand[IDX_W'(j)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  assign win_oh = ONE_HOT0 << win_idx;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  logic xfer_tail;

  // Tail transfer of the current owner: valid & ready & flit present & tail.
  assign xfer_tail = grant_vld_q && out_rdy_i &&
                     req_i[grant_idx_q] && tail_i[grant_idx_q];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    grant_vld_d = grant_vld_q;
    tie_d       = tie_q;
    rr_ptr_d    = rr_ptr_q;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d     = BUSY;
          grant_d     = win_oh;
          grant_idx_d = win_idx;
          grant_vld_d = 1'b1;
          tie_d       = multi_cand;
        end
      end

      BUSY: begin
        // Grant is locked. Only the owner's tail transfer ends the packet.
        // grant_idx is held after release. Only grant_vld_o qualifies it.
        if (xfer_tail) begin
          state_d     = IDLE;
          grant_d     = '0;
          grant_vld_d = 1'b0;
          tie_d       = 1'b0;
          rr_ptr_d    = (grant_idx_q == IDX_W'(IN_N-1)) ?
                        '0 : grant_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        grant_vld_d = 1'b0;
        tie_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      grant_vld_q <= 1'b0;
      tie_q       <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      grant_vld_q <= grant_vld_d;
      tie_q       <= tie_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = grant_idx_q;
  assign grant_vld_o = grant_vld_q;
  assign tie_o       = tie_q;
  assign state_dbg_o = (state_q == BUSY);

endmodule

// File: tb/tb_hop_cnt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hop_cnt_rr_arbiter
//
// Bench for hop_cnt_rr_arbiter with IN_N=5, HOP_CNT_W=3, AGE_W=2.
// A cycle-level reference model is built from integers and queues. It predicts
// every registered output. Directed scenarios also push their expected winner
// sequence into exp_q. Randomized traffic then runs against the model.
// Build with or without +define+HOP_ARB_AGING_EN. The model follows the macro.
// -----------------------------------------------------------------------------
module tb_hop_cnt_rr_arbiter;

  localparam int N    = 5;
  localparam int H    = 3;
  localparam int AW   = 2;
  localparam int AMAX = (1 << AW) - 1;

  // ---------------------------------------------------------------- clock/reset
  logic           clk;
  logic           rst_i;
  logic [N-1:0]   req_i;
  logic [N*H-1:0] hop_cnt_i;
  logic [N-1:0]   tail_i;
  logic           out_rdy_i;
  logic [N-1:0]   grant_o;
  logic [2:0]     grant_idx_o;
  logic           grant_vld_o;
  logic           tie_o;
  logic           state_dbg_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hop_cnt_rr_arbiter #(.IN_N(N), .HOP_CNT_W(H), .AGE_W(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .hop_cnt_i   (hop_cnt_i),
    .tail_i      (tail_i),
    .out_rdy_i   (out_rdy_i),
    .grant_o     (grant_o),
    .grant_idx_o (grant_idx_o),
    .grant_vld_o (grant_vld_o),
    .tie_o       (tie_o),
    .state_dbg_o (state_dbg_o)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  int m_busy, m_owner, m_tie, m_rr, m_idx;
  int m_age[N];

  task automatic model_step(input logic [N-1:0] req, input logic [N*H-1:0] hop,
                            input logic [N-1:0] tail, input logic rdy,
                            input logic rst);
    int cands[$];
    int maxh;
    int win;
    int c;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_tie = 0; m_rr = 0; m_idx = 0;
      for (int k = 0; k < N; k++) m_age[k] = 0;
    end else if (m_busy == 0) begin
      if (req != '0) begin
`ifdef HOP_ARB_AGING_EN
        for (int k = 0; k < N; k++)
          if (req[k] && m_age[k] == AMAX) cands.push_back(k);
`endif
        if (cands.size() == 0) begin
          maxh = -1;
          for (int k = 0; k < N; k++)
            if (req[k] && int'(hop[k*H +: H]) > maxh) maxh = int'(hop[k*H +: H]);
          for (int k = 0; k < N; k++)
            if (req[k] && int'(hop[k*H +: H]) == maxh) cands.push_back(k);
        end
        win = -1;
        for (int s = 0; s < N; s++) begin
          c = (m_rr + s) % N;
          if (win < 0)
            foreach (cands[i]) if (cands[i] == c) win = c;
        end
`ifdef HOP_ARB_AGING_EN
        for (int k = 0; k < N; k++) begin
          if (k == win) m_age[k] = 0;
          else if (req[k] && m_age[k] < AMAX) m_age[k] = m_age[k] + 1;
        end
`endif
        m_busy  = 1;
        m_owner = win;
        m_idx   = win;
        m_tie   = (cands.size() > 1) ? 1 : 0;
      end
    end else begin
      if (rdy && req[m_owner] && tail[m_owner]) begin
        m_busy = 0;
        m_tie  = 0;
        m_rr   = (m_owner + 1) % N;
      end
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step(input logic [N-1:0] req, input logic [N*H-1:0] hop,
                      input logic [N-1:0] tail, input logic rdy,
                      input logic rst);
    int pb;
    logic [N-1:0] one;
    logic [N-1:0] exp_grant;
    one = 1;
    pb  = m_busy;
    req_i = req; hop_cnt_i = hop; tail_i = tail; out_rdy_i = rdy; rst_i = rst;
    model_step(req, hop, tail, rdy, rst);
    @(posedge clk);
    #1;
    exp_grant = (m_busy != 0) ? (one << m_owner) : '0;
    check("grant", 32'(grant_o), 32'(exp_grant));
    check("vld", 32'(grant_vld_o), 32'(m_busy));
    check("tie", 32'(tie_o), 32'(m_tie));
    check("state", 32'(state_dbg_o), 32'(m_busy));
    if (m_busy != 0 || rst) check("idx", 32'(grant_idx_o), 32'(m_idx));
    if (m_busy != 0 && pb == 0 && exp_q.size() > 0)
      check("order", 32'(grant_idx_o), 32'(exp_q.pop_front()));
  endtask

  function automatic logic [N*H-1:0] hops(input int h0, input int h1,
                                          input int h2, input int h3,
                                          input int h4);
    logic [N*H-1:0] v;
    v = '0;
    v[0*H +: H] = H'(h0);
    v[1*H +: H] = H'(h1);
    v[2*H +: H] = H'(h2);
    v[3*H +: H] = H'(h3);
    v[4*H +: H] = H'(h4);
    return v;
  endfunction

  task automatic do_reset();
    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : main
    logic [N-1:0]   r;
    logic [N*H-1:0] hp;
    logic [N-1:0]   tl;
    int saw0;
    rst_i = 1'b1; req_i = '0; hop_cnt_i = '0; tail_i = '0; out_rdy_i = 1'b0;
    m_busy = 0; m_owner = 0; m_tie = 0; m_rr = 0; m_idx = 0;
    for (int k = 0; k < N; k++) m_age[k] = 0;

    // Reset state
    do_reset();
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_idx", 32'(grant_idx_o), 32'd0);

    // Max hop wins
    exp_q.push_back(8'd2);
    step(5'b00101, hops(2, 0, 5, 0, 0), 5'b11111, 1'b0, 1'b0);
    check("maxhop_grant", 32'(grant_o), 32'b00100);
    check("maxhop_tie", 32'(tie_o), 32'd0);
    step(5'b00100, hops(2, 0, 5, 0, 0), 5'b11111, 1'b1, 1'b0);
    check("maxhop_rel", 32'(grant_vld_o), 32'd0);

    // Tie with rotation
    do_reset();
    exp_q.push_back(8'd1); exp_q.push_back(8'd3);
    for (int i = 0; i < 4; i++) begin
      step(5'b01010, hops(0, 3, 0, 3, 0), 5'b11111, 1'b1, 1'b0);
      if (i == 0 || i == 2) check("rot_tie", 32'(tie_o), 32'd1);
    end
    check("rot_q", 32'(exp_q.size()), 32'd0);

    // Lock: tail without ready and a higher-hop newcomer do not release
    do_reset();
    exp_q.push_back(8'd1);
    step(5'b00010, hops(0, 1, 0, 0, 0), 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(5'b10010, hops(0, 1, 0, 0, 7), 5'b00010, 1'b0, 1'b0);
      check("lock_hold", 32'(grant_o), 32'b00010);
    end
    step(5'b10010, hops(0, 1, 0, 0, 7), 5'b00010, 1'b1, 1'b0);
    check("lock_rel", 32'(grant_o), 32'd0);

    // Reset mid-packet, then tie resolves from rr_ptr=0
    do_reset();
    exp_q.push_back(8'd1); exp_q.push_back(8'd3); exp_q.push_back(8'd1);
    step(5'b01010, hops(0, 3, 0, 3, 0), 5'b11111, 1'b1, 1'b0);
    step(5'b01010, hops(0, 3, 0, 3, 0), 5'b11111, 1'b1, 1'b0);
    step(5'b01010, hops(0, 3, 0, 3, 0), 5'b00000, 1'b1, 1'b0);
    step(5'b01010, hops(0, 3, 0, 3, 0), 5'b00000, 1'b1, 1'b0);
    step(5'b01010, hops(0, 3, 0, 3, 0), 5'b00000, 1'b1, 1'b1);
    check("midrst_grant", 32'(grant_o), 32'd0);
    check("midrst_tie", 32'(tie_o), 32'd0);
    step(5'b01010, hops(0, 3, 0, 3, 0), 5'b00000, 1'b0, 1'b0);
    check("midrst_idx", 32'(grant_idx_o), 32'd1);
    check("midrst_q", 32'(exp_q.size()), 32'd0);

    // Single requester, hop 0
    do_reset();
    exp_q.push_back(8'd4);
    step(5'b10000, hops(0, 0, 0, 0, 0), 5'b00000, 1'b0, 1'b0);
    check("single_idx", 32'(grant_idx_o), 32'd4);
    check("single_tie", 32'(tie_o), 32'd0);

    // Aging: input 0 (hop 0) against input 4 (hop 7) single-flit packets
    do_reset();
    exp_q.push_back(8'd4); exp_q.push_back(8'd4); exp_q.push_back(8'd4);
`ifdef HOP_ARB_AGING_EN
    exp_q.push_back(8'd0);
`else
    exp_q.push_back(8'd4);
`endif
    saw0 = 0;
    for (int i = 0; i < 8; i++) begin
      step(5'b10001, hops(0, 0, 0, 0, 7), 5'b11111, 1'b1, 1'b0);
      if (grant_vld_o && grant_idx_o == 3'd0) saw0 = 1;
    end
    check("aging_q", 32'(exp_q.size()), 32'd0);
`ifndef HOP_ARB_AGING_EN
    check("aging_off_no0", 32'(saw0), 32'd0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r  = N'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0)
        hp = hops($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1));
      else
        hp = (N*H)'($urandom);
      tl = N'($urandom_range(0, 31));
      step(r, hp, tl, ($urandom_range(0, 3) != 0), ($urandom_range(0, 80) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
